// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: fetch/data arbiter in front of one single-port sync memory
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                d_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int         BE_W       = DATA_W / 8;
  localparam int         LAT_W      = 3;
  localparam int         STV_W      = 4;
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STARVE_LIM = STV_W'(STARVE_MAX);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic              owner_data_q, owner_data_d;
  logic [LAT_W-1:0]  lat_cnt_q,    lat_cnt_d;
  logic [STV_W-1:0]  starve_q,     starve_d;
  logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;

  logic issue_ok;
  logic grant_data;
  logic grant_fetch;

  // Issue is suppressed during reset so the memory never sees a stray strobe.
  assign issue_ok    = (state_q == ST_IDLE) & ~reset;
  assign grant_data  = issue_ok & d_req & ~(if_req & (starve_q == STARVE_LIM));
  assign grant_fetch = issue_ok & ~grant_data & if_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_data_q <= 1'b1;
      lat_cnt_q    <= '0;
      starve_q     <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_data_q <= owner_data_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_q     <= starve_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_data_d = owner_data_q;
    lat_cnt_d    = lat_cnt_q;
    starve_d     = starve_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          owner_data_d = 1'b1;
          lat_cnt_d    = LAT_INIT;
          state_d      = d_we ? ST_DONE : ST_WAIT;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (grant_fetch) begin
          owner_data_d = 1'b0;
          lat_cnt_d    = LAT_INIT;
          state_d      = ST_WAIT;
          starve_d     = '0;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        // Count of 1 marks the cycle the memory presents read data.
        if (lat_cnt_q == 3'd1) begin
          state_d = ST_DONE;
          if (owner_data_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (grant_data) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (grant_fetch) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_be    = {BE_W{1'b1}};
    end

    if_valid = (state_q == ST_DONE) & ~owner_data_q;
    d_valid  = (state_q == ST_DONE) &  owner_data_q;
    if_stall = if_req & ~if_valid;
    d_stall  = d_req & ~d_valid;
    if_rdata = if_rdata_q;
    d_rdata  = d_rdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: directed and random checks against a transaction model
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid, if_stall;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [DATA_W-1:0] d_wdata = '0;
  logic [BE_W-1:0]   d_be = '0;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid, d_stall;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Environment memory: answers exactly MEM_LAT cycles after the strobe, noise otherwise.
  logic [31:0] emem [512];
  logic [31:0] mmem [512];
  logic [31:0] pipe [MEM_LAT];
  assign mem_rdata = pipe[MEM_LAT-1];

  initial begin
    for (int a = 0; a < 512; a++) begin
      emem[a] = 32'hC0DE0000 | 32'(a);
      mmem[a] = 32'hC0DE0000 | 32'(a);
    end
    emem[4] = 32'h00A00093;
    mmem[4] = 32'h00A00093;
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
  end

  always @(posedge clk) begin
    pipe[0] <= (mem_en === 1'b1 && mem_we === 1'b0) ? emem[mem_addr] : $urandom;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    if (mem_en === 1'b1 && mem_we === 1'b1)
      for (int b = 0; b < BE_W; b++)
        if (mem_be[b]) emem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Transaction model: one access at a time, busy until free_at, ack at done_at.
  int          cyc = 0;
  int          free_at = 0;
  int          done_at = -1;
  int          starve = 0;
  bit          m_own_d, m_wr;
  logic [31:0] m_rd_val, m_if_rdata, m_d_rdata;
  logic        e_en, e_we, e_ifv, e_dv;
  logic [8:0]  e_addr;
  logic [31:0] e_wd;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      free_at = cyc + 1;
      done_at = -1;
      starve = 0;
      m_if_rdata = '0;
      m_d_rdata = '0;
    end else begin
      e_ifv = (cyc == done_at) && !m_own_d;
      e_dv  = (cyc == done_at) && m_own_d;
      if (cyc == done_at && !m_wr) begin
        if (m_own_d) m_d_rdata = m_rd_val;
        else         m_if_rdata = m_rd_val;
      end
      e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_be = '0;
      if (cyc >= free_at) begin
        if (d_req && !(if_req && starve == STARVE_MAX)) begin
          e_en = 1; e_we = d_we; e_addr = d_addr; e_wd = d_wdata; e_be = d_be;
          m_own_d = 1; m_wr = d_we;
          starve = if_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
        end else if (if_req) begin
          e_en = 1; e_addr = if_addr; e_be = 4'hF;
          m_own_d = 0; m_wr = 0;
          starve = 0;
        end
        if (e_en) begin
          m_rd_val = mmem[e_addr];
          if (m_wr)
            for (int b = 0; b < BE_W; b++)
              if (e_be[b]) mmem[e_addr][8*b +: 8] = e_wd[8*b +: 8];
          done_at = cyc + (m_wr ? 1 : MEM_LAT + 1);
          free_at = done_at + 1;
        end
      end
      chk("mem_en",    32'(mem_en),    32'(e_en));
      chk("mem_we",    32'(mem_we),    32'(e_we));
      chk("mem_addr",  32'(mem_addr),  32'(e_addr));
      chk("mem_wdata", mem_wdata,      e_wd);
      chk("mem_be",    32'(mem_be),    32'(e_be));
      chk("if_valid",  32'(if_valid),  32'(e_ifv));
      chk("d_valid",   32'(d_valid),   32'(e_dv));
      chk("if_rdata",  if_rdata,       m_if_rdata);
      chk("d_rdata",   d_rdata,        m_d_rdata);
      chk("if_stall",  32'(if_stall),  32'(if_req & ~e_ifv));
      chk("d_stall",   32'(d_stall),   32'(d_req & ~e_dv));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit seen_iv, seen_dv;
  int g_off[$];
  bit g_f[$];
  int exp_off[4] = '{0, 4, 8, 12};
  bit exp_f[4]   = '{0, 0, 1, 0};

  initial begin
    repeat (3) tick();
    tick(); reset = 0;
    @(negedge clk);
    chk("rst_mem_en",   32'(mem_en),   32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_rdata", if_rdata,      32'd0);
    chk("rst_d_rdata",  d_rdata,       32'd0);

    // Single fetch, latency 2: ack three cycles after issue.
    tick(); if_req = 1; if_addr = 9'h004;
    @(negedge clk);
    chk("t1_mem_en",   32'(mem_en),   32'd1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h004);
    chk("t1_stall0",   32'(if_stall), 32'd1);
    tick(); @(negedge clk); chk("t1_stall1", 32'(if_stall), 32'd1);
    tick(); @(negedge clk); chk("t1_stall2", 32'(if_stall), 32'd1);
    tick(); @(negedge clk);
    chk("t1_if_valid", 32'(if_valid), 32'd1);
    chk("t1_if_rdata", if_rdata,      32'h00A00093);
    tick(); if_req = 0;

    // Simultaneous requests: data first, fetch at the following idle.
    tick(); if_req = 1; if_addr = 9'h008; d_req = 1; d_we = 0; d_addr = 9'h010;
    @(negedge clk);
    chk("t2_mem_addr", 32'(mem_addr), 32'h010);
    chk("t2_mem_we",   32'(mem_we),   32'd0);
    tick(); tick(); tick(); @(negedge clk);
    chk("t2_d_valid",  32'(d_valid),  32'd1);
    chk("t2_if_valid", 32'(if_valid), 32'd0);
    chk("t2_d_rdata",  d_rdata,       32'hC0DE0010);
    tick(); d_req = 0; @(negedge clk);
    chk("t2_f_issue",  32'(mem_addr), 32'h008);
    tick(); tick(); tick(); @(negedge clk);
    chk("t2_if_valid2", 32'(if_valid), 32'd1);
    chk("t2_if_rdata",  if_rdata,      32'hC0DE0008);
    tick(); if_req = 0;

    // Partial store, then read it back.
    tick(); d_req = 1; d_we = 1; d_addr = 9'h020; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    @(negedge clk);
    chk("t4_mem_we",    32'(mem_we),  32'd1);
    chk("t4_mem_be",    32'(mem_be),  32'h3);
    chk("t4_mem_wdata", mem_wdata,    32'hDEADBEEF);
    tick(); @(negedge clk);
    chk("t4_d_valid", 32'(d_valid), 32'd1);
    chk("t4_d_rdata", d_rdata,      32'hC0DE0010);
    tick(); d_req = 0; d_we = 0;
    tick(); d_req = 1; d_addr = 9'h020;
    tick(); tick(); tick(); @(negedge clk);
    chk("t4_rb_valid", 32'(d_valid), 32'd1);
    chk("t4_rb_rdata", d_rdata,      32'hC0DEBEEF);
    tick(); d_req = 0;

    // Anti-starvation: data, data, fetch, data.
    g_off.delete(); g_f.delete(); seen_dv = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) begin
        if_req = 1; if_addr = 9'h100; d_req = 1; d_we = 0; d_addr = 9'h040;
      end else if (seen_dv) begin
        d_addr = d_addr + 9'd1;
      end
      @(negedge clk);
      if (mem_en) begin
        g_off.push_back(k);
        g_f.push_back(mem_addr == 9'h100);
      end
      seen_dv = d_valid;
    end
    tick(); if_req = 0; d_req = 0;
    chk("t3_grant_count", 32'(g_off.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < g_off.size()) begin
        chk("t3_grant_cycle", 32'(g_off[i]), 32'(exp_off[i]));
        chk("t3_grant_fetch", 32'(g_f[i]),   32'(exp_f[i]));
      end
    end

    // Reset while a fetch waits on memory.
    tick(); if_req = 1; if_addr = 9'h004;
    tick(); reset = 1; if_req = 0;
    tick(); reset = 0; @(negedge clk);
    chk("t5_mem_en",   32'(mem_en),   32'd0);
    chk("t5_if_valid", 32'(if_valid), 32'd0);
    chk("t5_if_rdata", if_rdata,      32'd0);
    chk("t5_d_rdata",  d_rdata,       32'd0);
    chk("t5_if_stall", 32'(if_stall), 32'd0);
    tick(); @(negedge clk); chk("t5_no_late_valid", 32'(if_valid), 32'd0);
    tick(); if_req = 1; if_addr = 9'h004;
    tick(); tick(); tick(); @(negedge clk);
    chk("t5_refetch_valid", 32'(if_valid), 32'd1);
    chk("t5_refetch_rdata", if_rdata,      32'h00A00093);
    tick(); if_req = 0;

    // Back-to-back fetches: one issue every MEM_LAT+2 cycles.
    seen_iv = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        if_req = 1; if_addr = 9'h00C;
      end else if (seen_iv) begin
        if_addr = if_addr + 9'd1;
      end
      @(negedge clk);
      chk("t6_mem_en",   32'(mem_en),   32'(k % 4 == 0));
      chk("t6_if_valid", 32'(if_valid), 32'(k % 4 == 3));
      seen_iv = if_valid;
    end
    tick(); if_req = 0;

    // Random traffic with occasional resets.
    seen_iv = 0; seen_dv = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 399) == 0);
      if (!if_req || seen_iv) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 9'($urandom_range(0, 31));
      end
      if (!d_req || seen_dv) begin
        d_req   = ($urandom_range(0, 99) < 50);
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 9'($urandom_range(0, 31));
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
      @(negedge clk);
      seen_iv = if_valid;
      seen_dv = d_valid;
    end
    tick(); reset = 0; if_req = 0; d_req = 0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the pipeline's instruction-fetch port and its data (load/store) port for the unified-memory build of the 5-stage core. It serialises requests with data-priority arbitration and an anti-starvation override. It sequences each access through a fixed-latency state machine and returns per-requester valid pulses. It drives the stall signals the PC register and pipeline buffers use to freeze while a port waits.

Parameters:
ADDR_W, 9, memory address width in bits (matches PC/DM address width).
DATA_W, 32, data width in bits.
MEM_LAT, 1, memory read latency in cycles, from mem_en to mem_rdata valid; legal range 1..4.
STARVE_MAX, 4, maximum consecutive data grants while if_req is pending before fetch is forced; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; level, held until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req
if_rdata  out  DATA_W  fetched instruction; valid when if_valid
if_valid  out  1  one-cycle fetch completion pulse
if_stall  out  1  if_req & ~if_valid
d_req  in  1  data request; level, held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  load data; valid when d_valid
d_valid  out  1  one-cycle data completion pulse
d_stall  out  1  d_req & ~d_valid
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, MEM_LAT cycles after mem_en

Behaviour:
- Reset values:
  - State IDLE.
  - if_valid, d_valid, mem_en, mem_we = 0.
  - if_rdata, d_rdata, mem_addr, mem_wdata, mem_be = 0.
  - Starve counter = 0; owner = data.
- States: IDLE, WAIT, DONE. Only one access is outstanding at a time.
- IDLE, arbitration (combinational, issued the same cycle):
  - If d_req and not (if_req and starve==STARVE_MAX): grant data.
  - Else if if_req: grant fetch.
  - Else: stay IDLE, mem_en=0.
- Issue cycle:
  - mem_en=1; mem_addr is the granted address.
  - Fetch: mem_we=0, mem_be=all ones, mem_wdata=0.
  - Data: mem_we=d_we, mem_be=d_be, mem_wdata=d_wdata.
  - Owner is latched.
- Transitions after issue:
  - Store goes to DONE next cycle. Ack at issue+1; no read data.
  - Load or fetch goes to WAIT with counter=MEM_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, mem_rdata is captured into the owner's rdata register and the FSM goes to DONE.
  - Read valid is therefore at issue+MEM_LAT+1.
- DONE:
  - Owner's valid=1 for exactly one cycle; no issue in this cycle. Next state IDLE.
  - Back-to-back occupancy: store 2 cycles, read MEM_LAT+2 cycles.
- Starve counter:
  - On a data grant while if_req=1: increment, saturating at STARVE_MAX.
  - On a fetch grant, or a data grant with if_req=0: clear.
- rdata registers hold their last captured value until overwritten. The non-owner's rdata is never modified.
- mem_* outputs are 0 in every cycle except the issue cycle.
- Requests arriving while not in IDLE are held by the requester and considered at the next IDLE.
- Request rules:
  - A requester dropping req mid-access is illegal; the access still completes and valid still pulses.
  - Changing addr/wdata after issue has no effect.
- Reset mid-operation: FSM returns to IDLE next cycle. In-flight read data is discarded, no valid pulse, counters cleared.
- Widths: addresses pass through unmodified; no alignment checks or translation.

Test Plan:
1. MEM_LAT=2, if_req=1, if_addr=0x004, memory returns 0x00A00093 → mem_en at T, if_valid and if_rdata=0x00A00093 at T+3, if_stall high T..T+2.
2. if_req and d_req both rise at T (load, d_addr=0x010) → data issued at T. Fetch issued at the IDLE after data's DONE. d_valid precedes if_valid.
3. STARVE_MAX=2, d_req held continuously with new loads, if_req held → grants go data, data, fetch, then data resumes. Starve counter returns to 0 after the fetch.
4. Store d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF, d_be=4'b0011 → mem_en=mem_we=1, mem_be=4'b0011 at T; d_valid at T+1; d_rdata unchanged.
5. Reset asserted during WAIT of a fetch → no if_valid, state IDLE, all outputs 0 the following cycle. A new fetch after reset completes normally.
6. MEM_LAT=4, continuous fetches with no data requests → mem_en pulses every 6 cycles. if_valid at issue+5; mem_en never high in the DONE cycle.
